// File: rtl/simple_processor_pkg.sv
// Shared types and widths for the multi-cycle successor core.
// Opcode map, FSM states and the default address/data widths live here.
package simple_processor_pkg;

  localparam int ADDR_WIDTH    = 16;
  localparam int DATA_WIDTH    = 16;
  localparam int INSTR_WIDTH   = 16;
  localparam int NUM_REGS      = 8;
  localparam int REG_IDX_WIDTH = 3;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_ADDI  = 4'h7,
    OP_LW    = 4'h8,
    OP_SW    = 4'h9,
    OP_BEQ   = 4'hA,
    OP_JAL   = 4'hB,
    OP_NOP_C = 4'hC,
    OP_NOP_D = 4'hD,
    OP_NOP_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_HALT = 2'd3
  } core_state_e;

  // Opcodes whose result comes from the ALU and lands in rd.
  function automatic logic is_alu_op(input opcode_e op);
    logic res;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_ADDI: res = 1'b1;
      default:                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sp_alu.sv
// Combinational ALU for the successor core.
// Shifts use only the low log2(DW) bits of b; SRL is logical.
module sp_alu
  import simple_processor_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  opcode_e         op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] shamt_s;

  assign shamt_s = b[SHW-1:0];

  // Result select by opcode; non-ALU opcodes yield zero.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB:          result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_SLL:          result = a << shamt_s;
      OP_SRL:          result = a >> shamt_s;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/simple_processor_mc.sv
// Multi-cycle core: single-cycle ALU/branch execution, handshaked load/store.
// Register file, decoder and BOOT/EXEC/MEM/HALT control are kept inline.
module simple_processor_mc
  import simple_processor_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                      dmem_ack_i,
  output logic                      halted_o,
  output logic                      retire_o
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int DW = MEM_DATA_WIDTH;
  localparam logic [AW-1:0] PC_STEP = AW'(2'd2);

  core_state_e              state_r, state_nxt_s;
  logic [AW-1:0]            pc_r, pc_nxt_s;
  logic [DW-1:0]            rf_r [NUM_REGS];
  logic [AW-1:0]            mem_addr_r;
  logic [DW-1:0]            mem_wdata_r;
  logic [REG_IDX_WIDTH-1:0] mem_rd_r;
  logic                     mem_we_r;

  logic [INSTR_WIDTH-1:0]   instr_s;
  opcode_e                  op_s;
  logic [REG_IDX_WIDTH-1:0] rd_s, rs1_s, rs2_s;
  logic [5:0]               imm6_s;
  logic [DW-1:0]            rs1_val_s, rs2_val_s, imm_dw_s, alu_b_s, alu_res_s, link_s;
  logic [AW-1:0]            imm_aw_s, br_off_s, pc_inc_s, ea_s;

  logic                     rf_we_s;
  logic [REG_IDX_WIDTH-1:0] rf_waddr_s;
  logic [DW-1:0]            rf_wdata_s;
  logic                     mem_load_s;
  logic                     retire_s;

  assign instr_s = imem_rdata_i[INSTR_WIDTH-1:0];
  assign op_s    = opcode_e'(instr_s[15:12]);
  assign rd_s    = instr_s[11:9];
  assign rs1_s   = instr_s[8:6];
  assign rs2_s   = instr_s[5:3];
  assign imm6_s  = instr_s[5:0];

  assign rs1_val_s = (rs1_s == 3'd0) ? '0 : rf_r[rs1_s];
  assign rs2_val_s = (rs2_s == 3'd0) ? '0 : rf_r[rs2_s];

  assign imm_dw_s = {{(DW-6){imm6_s[5]}}, imm6_s};
  assign imm_aw_s = {{(AW-6){imm6_s[5]}}, imm6_s};
  assign br_off_s = {imm_aw_s[AW-2:0], 1'b0};
  assign pc_inc_s = pc_r + PC_STEP;
  assign link_s   = DW'(pc_inc_s);
  assign ea_s     = AW'(rs1_val_s) + imm_aw_s;
  assign alu_b_s  = (op_s == OP_ADDI) ? imm_dw_s : rs2_val_s;

  sp_alu #(.DW(DW)) u_alu (
    .op     (op_s),
    .a      (rs1_val_s),
    .b      (alu_b_s),
    .result (alu_res_s)
  );

  // Next-state, next-PC, register write and retire decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    rf_we_s     = 1'b0;
    rf_waddr_s  = rd_s;
    rf_wdata_s  = alu_res_s;
    mem_load_s  = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      ST_BOOT: begin
        pc_nxt_s    = boot_addr_i;
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_alu_op(op_s)) begin
          rf_we_s  = 1'b1;
          pc_nxt_s = pc_inc_s;
          retire_s = 1'b1;
        end else begin
          case (op_s)
            OP_LW, OP_SW: begin
              mem_load_s  = 1'b1;
              state_nxt_s = ST_MEM;
            end
            OP_BEQ: begin
              pc_nxt_s = (rs1_val_s == rs2_val_s) ? (pc_r + br_off_s) : pc_inc_s;
              retire_s = 1'b1;
            end
            OP_JAL: begin
              rf_we_s    = 1'b1;
              rf_wdata_s = link_s;
              pc_nxt_s   = pc_r + br_off_s;
              retire_s   = 1'b1;
            end
            OP_HALT: begin
              state_nxt_s = ST_HALT;
              retire_s    = 1'b1;
            end
            default: begin
              pc_nxt_s = pc_inc_s;
              retire_s = 1'b1;
            end
          endcase
        end
      end
      ST_MEM: begin
        if (dmem_ack_i) begin
          rf_we_s     = ~mem_we_r;
          rf_waddr_s  = mem_rd_r;
          rf_wdata_s  = dmem_rdata_i;
          pc_nxt_s    = pc_inc_s;
          retire_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // Control state, PC and the request registers held stable through MEM.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r     <= ST_BOOT;
      pc_r        <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_rd_r    <= '0;
      mem_we_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (mem_load_s) begin
        mem_addr_r  <= ea_s;
        mem_wdata_r <= rs2_val_s;
        mem_rd_r    <= rd_s;
        mem_we_r    <= (op_s == OP_SW);
      end
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_r[i] <= '0;
      end
    end else if (rf_we_s && (rf_waddr_s != 3'd0)) begin
      rf_r[rf_waddr_s] <= rf_wdata_s;
    end
  end

  assign imem_req_o   = (state_r == ST_EXEC);
  assign imem_addr_o  = pc_r;
  assign dmem_req_o   = (state_r == ST_MEM);
  assign dmem_we_o    = mem_we_r;
  assign dmem_addr_o  = mem_addr_r;
  assign dmem_wdata_o = mem_wdata_r;
  assign halted_o     = (state_r == ST_HALT);
  assign retire_o     = retire_s;

endmodule
